// File: rtl/tx_frame_fsm.sv
// tx_frame_fsm: serial frame transmitter (start, LSB-first data, optional parity, stop bits) gated by clear-to-send.
module tx_frame_fsm #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cts,
    input  logic              tx_abort,
    output logic              tx_ready,
    output logic              tx_dout,
    output logic              busy,
    output logic              success
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          ODD       = PARITY_ODD != 0;

    typedef enum logic [2:0] {IDLE, WAIT_CTS, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              tx_ready_q, tx_ready_d;
    logic              tx_dout_q, tx_dout_d;
    logic              busy_q, busy_d;
    logic              success_q, success_d;
    logic              wrap;
    logic [CW-1:0]     step;

    assign wrap = cnt_q == LAST_CNT;
    assign step = wrap ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        success_d = 1'b0;
        if (state_q != IDLE && tx_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (tx_valid) begin
                    state_d = WAIT_CTS;
                    shift_d = tx_data;
                    par_d   = (^tx_data) ^ ODD;
                end
                WAIT_CTS: if (cts) begin
                    state_d = START;
                    cnt_d   = '0;
                end
                START: begin
                    cnt_d = step;
                    if (wrap) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    cnt_d = step;
                    if (wrap && bit_q == LAST_BIT) begin
                        state_d = PARITY_EN != 0 ? PARITY : STOP;
                        bit_d   = '0;
                    end else if (wrap) begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
                PARITY: begin
                    cnt_d = step;
                    if (wrap) state_d = STOP;
                end
                STOP: begin
                    cnt_d = step;
                    if (wrap && bit_q == LAST_STOP) begin
                        state_d   = IDLE;
                        bit_d     = '0;
                        success_d = 1'b1;
                    end else if (wrap) begin
                        bit_d = bit_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // outputs are registered from the next state so they line up with it
        tx_ready_d = state_d == IDLE;
        busy_d     = state_d != IDLE;
        tx_dout_d  = state_d == START  ? 1'b0 :
                     state_d == DATA   ? shift_d[0] :
                     state_d == PARITY ? par_q : 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_dout_q  <= 1'b1;
            busy_q     <= 1'b0;
            success_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_ready_q <= tx_ready_d;
            tx_dout_q  <= tx_dout_d;
            busy_q     <= busy_d;
            success_q  <= success_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign tx_dout  = tx_dout_q;
    assign busy     = busy_q;
    assign success  = success_q;
endmodule
